host_spi_master: RTL

//  Initiator end of the host SPI link: SPI mode-0 master, MSB-first, 16-bit words.

---
 rtl/host_spi_master_pkg.sv | 18 +
 rtl/host_spi_master_if.sv | 34 +++
 rtl/host_spi_master_shift16.sv | 61 ++++++
 rtl/host_spi_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/host_spi_master_pkg.sv
// host_spi_master_pkg: shared constants and the FSM state encoding for the
// host SPI master slice (word width, state enum, timer sizing).
package host_spi_master_pkg;

  localparam int SPI_WORD_W = 16;

  // Timer is shared by CS setup, SCLK half-periods and CS hold.
  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/host_spi_master_if.sv
// host_spi_master_if: request/data handshake between a host-side controller
// and the SPI master.
//   start/cs_sel/nwords/abort : transaction request and cancel
//   tx_data/tx_ready          : TX word and its consumed pulse
//   rx_data/rx_valid          : received word and its update pulse
//   busy/done                 : transaction status
// modport master = controller side, modport slave = SPI master side.
interface host_spi_master_if #(
  parameter int NW_W = 10
);
  import host_spi_master_pkg::*;

  logic                  start;
  logic                  cs_sel;
  logic [NW_W-1:0]       nwords;
  logic                  abort;
  logic [SPI_WORD_W-1:0] tx_data;
  logic                  tx_ready;
  logic [SPI_WORD_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cs_sel, nwords, abort, tx_data,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, cs_sel, nwords, abort, tx_data,
    output tx_ready, rx_data, rx_valid, busy, done
  );

endinterface

// File: rtl/host_spi_master_shift16.sv
// host_spi_master_shift16: 16-bit parallel-load, serial-in/serial-out shift
// register for an MSB-first mode-0 master.
//   clk, rst_n   : clock, async active-low reset
//   clear        : synchronous clear (abort)
//   load         : load load_data; mosi takes bit 15 immediately
//   load_data    : next TX word
//   sample       : capture miso (SCLK rising phase)
//   shift_out    : advance one bit (SCLK falling phase)
//   drain        : with shift_out, drive mosi low (last bit of last word)
//   miso         : serial input
//   mosi         : registered serial output (is bit 15 of the word)
//   word_in      : word as it will stand after the current shift
module host_spi_master_shift16
  import host_spi_master_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [SPI_WORD_W-1:0] load_data,
  input  logic                  sample,
  input  logic                  shift_out,
  input  logic                  drain,
  input  logic                  miso,
  output logic                  mosi,
  output logic [SPI_WORD_W-1:0] word_in
);

  // Bits 14..0 of the shifting word; bit 15 lives in mosi itself.
  logic [SPI_WORD_W-2:0] lo;
  logic                  sbit;

  // Received bits enter at the bottom, so the full RX word is the lower
  // fifteen bits plus the bit captured on the latest rising phase.
  assign word_in = {lo, sbit};

  // Shift register, output bit and sampled MISO bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi <= 1'b0;
      lo   <= '0;
      sbit <= 1'b0;
    end else if (clear) begin
      mosi <= 1'b0;
      lo   <= '0;
      sbit <= 1'b0;
    end else begin
      if (load) begin
        mosi <= load_data[SPI_WORD_W-1];
        lo   <= load_data[SPI_WORD_W-2:0];
      end else if (shift_out) begin
        mosi <= drain ? 1'b0 : lo[SPI_WORD_W-2];
        lo   <= {lo[SPI_WORD_W-3:0], sbit};
      end
      if (sample) begin
        sbit <= miso;
      end
    end
  end

endmodule

// File: rtl/host_spi_master.sv
// host_spi_master: SPI mode-0 master, MSB-first, 16-bit full-duplex words,
// two chip selects. Divider, bit/word counters and FSM live here; the data
// path is host_spi_master_shift16.
//   clk, rst_n : clock, async active-low reset
//   bus        : host_spi_master_if.slave (start/abort request, TX/RX words,
//                busy/done status)
//   spi_sclk   : SCLK, idle low
//   spi_cs_n   : active-low chip selects, idle 2'b11
//   spi_mosi   : master data out
//   spi_miso   : slave data in (already synchronised)
module host_spi_master
  import host_spi_master_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int NW_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  host_spi_master_if.slave  bus,
  output logic              spi_sclk,
  output logic [1:0]        spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [NW_W-1:0] NW_ZERO = {NW_W{1'b0}};
  localparam logic [NW_W-1:0] NW_ONE  = {{(NW_W-1){1'b0}}, 1'b1};

  spi_state_e            state;
  spi_state_e            state_nx;
  logic [TMR_W-1:0]      tmr;
  logic [3:0]            bit_cnt;
  logic [NW_W-1:0]       words_left;
  logic [SPI_WORD_W-1:0] word_in;

  logic tmr_end, go, empty, abort_now, rise, fall, word_end, finish, more, reload;

  assign more   = (words_left != NW_ONE);
  assign reload = go || (word_end && more);

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_nx  = state;
    tmr_end   = 1'b0;
    go        = 1'b0;
    empty     = 1'b0;
    abort_now = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    word_end  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort is meaningless here, so a simultaneous start simply wins
        if (bus.start) begin
          if (bus.nwords != NW_ZERO) begin
            go       = 1'b1;
            state_nx = ST_SETUP;
          end else begin
            empty    = 1'b1;
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        tmr_end = (tmr == TMR_W'(CS_SETUP - 1));
        if (bus.abort) begin
          abort_now = 1'b1;
          state_nx  = ST_IDLE;
        end else if (tmr_end) begin
          state_nx = ST_SHIFT;
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        tmr_end = (tmr == TMR_W'(DIV - 1));
        if (bus.abort) begin
          abort_now = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          rise     = tmr_end && !spi_sclk;
          fall     = tmr_end && spi_sclk;
          word_end = fall && (bit_cnt == 4'd15);
          if (word_end && !more) begin
            state_nx = ST_HOLD;
          end else begin
            state_nx = ST_SHIFT;
          end
        end
      end
      ST_HOLD: begin
        tmr_end = (tmr == TMR_W'(CS_HOLD - 1));
        if (bus.abort) begin
          abort_now = 1'b1;
          state_nx  = ST_IDLE;
        end else if (tmr_end) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Phase timer: restarts on every state change and every expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == ST_IDLE || state_nx != state || tmr_end) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_ONE;
    end
  end

  // Bit and word counters; the word count is latched at start and only
  // counts down, so changes on nwords mid-transaction are not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      words_left <= NW_ZERO;
    end else if (go) begin
      bit_cnt    <= 4'd0;
      words_left <= bus.nwords;
    end else begin
      if (fall) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (word_end) begin
        words_left <= words_left - NW_ONE;
      end
    end
  end

  // Registered handshake, status and SPI pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sclk     <= 1'b0;
      spi_cs_n     <= 2'b11;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else if (abort_now) begin
      // partial word is dropped: rx_data keeps the last complete word
      spi_sclk     <= 1'b0;
      spi_cs_n     <= 2'b11;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.tx_ready <= reload;
      bus.rx_valid <= word_end;
      bus.done     <= empty || finish;
      if (go) begin
        bus.busy <= 1'b1;
        spi_cs_n <= bus.cs_sel ? 2'b01 : 2'b10;
      end else if (finish) begin
        bus.busy <= 1'b0;
        spi_cs_n <= 2'b11;
      end
      if (rise) begin
        spi_sclk <= 1'b1;
      end else if (fall) begin
        spi_sclk <= 1'b0;
      end
      if (word_end) begin
        bus.rx_data <= word_in;
      end
    end
  end

  host_spi_master_shift16 u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort_now),
    .load      (reload),
    .load_data (bus.tx_data),
    .sample    (rise),
    .shift_out (fall),
    .drain     (word_end && !more),
    .miso      (spi_miso),
    .mosi      (spi_mosi),
    .word_in   (word_in)
  );

endmodule
